// File: rtl/ula_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
package ula_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  localparam int FLAGS_W       = 5;
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_OVF      = 2;
  localparam int FLAG_DIV_ZERO = 3;
  localparam int FLAG_ILLEGAL  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Request/response channel of the sequential ALU.
interface ula_seq_if
  import ula_seq_pkg::*;
#(
  parameter int DATA_SIZE = 11
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           opcode;
  logic [DATA_SIZE-1:0] operand_a;
  logic [DATA_SIZE-1:0] operand_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out;
  logic [FLAGS_W-1:0]   flags;

  modport master (
    output in_valid, opcode, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/ula_muldiv.sv
// Iterative shift-add multiplier / restoring divider; one bit per cycle, DATA_SIZE cycles.
module ula_muldiv
  import ula_seq_pkg::*;
#(
  parameter int DATA_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic                 done,
  output logic [DATA_SIZE-1:0] result,
  output logic [DATA_SIZE-1:0] rem,
  output logic                 ovf
);
  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  logic                 is_mul;
  // hi:lo is the product for MUL, remainder:quotient for DIV/MOD
  logic [DATA_SIZE-1:0] hi;
  logic [DATA_SIZE-1:0] lo;
  logic [DATA_SIZE-1:0] m;
  logic [DATA_SIZE:0]   mul_sum;
  logic [DATA_SIZE:0]   trial;
  logic [DATA_SIZE:0]   diff;
  logic                 ge;

  always_comb begin
    mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
    trial   = {hi, lo[DATA_SIZE-1]};
    diff    = trial - {1'b0, m};
    ge      = (trial >= {1'b0, m});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(DATA_SIZE);
    end else if (busy) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      else           busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      is_mul <= (op == OP_MUL);
      hi     <= '0;
      lo     <= (op == OP_MUL) ? b : a;
      m      <= (op == OP_MUL) ? a : b;
    end else if (busy && (cnt != '0)) begin
      if (is_mul) begin
        hi <= mul_sum[DATA_SIZE:1];
        lo <= {mul_sum[0], lo[DATA_SIZE-1:1]};
      end else begin
        // A zero divisor always "fits": quotient fills with ones, remainder ends as A
        hi <= ge ? diff[DATA_SIZE-1:0] : trial[DATA_SIZE-1:0];
        lo <= {lo[DATA_SIZE-2:0], ge};
      end
    end
  end

  assign done   = busy && (cnt == '0);
  assign result = lo;
  assign rem    = hi;
  assign ovf    = |hi;

endmodule

// File: rtl/ula_seq.sv
// Handshaked sequential ALU: operands captured on accept, result and flags held until consumed.
module ula_seq
  import ula_seq_pkg::*;
#(
  parameter int DATA_SIZE  = 11,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic     clk,
  input logic     reset,
  ula_seq_if.slave bus
);
  state_e               state;
  logic [3:0]           op_q;
  logic [DATA_SIZE-1:0] a_q;
  logic [DATA_SIZE-1:0] b_q;
  logic [DATA_SIZE-1:0] out_q;
  logic [FLAGS_W-1:0]   flags_q;
  logic                 accept;
  logic                 md_start;
  logic                 md_done;
  logic                 md_ovf;
  logic [DATA_SIZE-1:0] md_result;
  logic [DATA_SIZE-1:0] md_rem;
  logic [DATA_SIZE+FLAGS_W-1:0] alu_word;
  logic [DATA_SIZE-1:0] iter_res;
  logic [FLAGS_W-1:0]   iter_flags;

  // Single-cycle operations; returns {flags, result}
  function automatic logic [DATA_SIZE+FLAGS_W-1:0] alu_eval(
    input logic [3:0]           op,
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b
  );
    logic [DATA_SIZE:0]          sum;
    logic signed [DATA_SIZE-1:0] sa;
    logic signed [DATA_SIZE-1:0] sb;
    logic                        gt;
    logic [DATA_SIZE-1:0]        r;
    logic [FLAGS_W-1:0]          f;
    sum = '0;
    sa  = a;
    sb  = b;
    gt  = SIGNED_CMP ? (sa > sb) : (a > b);
    r   = '0;
    f   = '0;
    case (op)
      OP_ADD: begin
        sum           = {1'b0, a} + {1'b0, b};
        r             = sum[DATA_SIZE-1:0];
        f[FLAG_CARRY] = sum[DATA_SIZE];
      end
      OP_SUB: begin
        r             = a - b;
        f[FLAG_CARRY] = (a < b);
      end
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_CMP: begin
        if (gt)          r = DATA_SIZE'(1);
        else if (a == b) r = '0;
        else             r = '1;
      end
      // Logical shifts by DATA_SIZE or more already yield zero
      OP_SHL:  r = a << b;
      OP_SHR:  r = a >> b;
      default: f[FLAG_ILLEGAL] = 1'b1;
    endcase
    f[FLAG_ZERO] = (r == '0);
    return {f, r};
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign md_start = accept && is_iter_op(bus.opcode);
  assign alu_word = alu_eval(op_q, a_q, b_q);

  always_comb begin
    iter_res                 = (op_q == OP_MOD) ? md_rem : md_result;
    iter_flags               = '0;
    iter_flags[FLAG_OVF]     = (op_q == OP_MUL) && md_ovf;
    iter_flags[FLAG_DIV_ZERO] = (op_q != OP_MUL) && (b_q == '0);
    iter_flags[FLAG_ZERO]    = (iter_res == '0);
  end

  ula_muldiv #(.DATA_SIZE(DATA_SIZE)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (bus.opcode),
    .a      (bus.operand_a),
    .b      (bus.operand_b),
    .done   (md_done),
    .result (md_result),
    .rem    (md_rem),
    .ovf    (md_ovf)
  );

  // Capture stage: operands frozen at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.opcode;
      a_q  <= bus.operand_a;
      b_q  <= bus.operand_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) state <= is_iter_op(bus.opcode) ? ITER : EXEC;
        end
        EXEC: begin
          state   <= DONE;
          out_q   <= alu_word[DATA_SIZE-1:0];
          flags_q <= alu_word[DATA_SIZE+FLAGS_W-1:DATA_SIZE];
        end
        ITER: begin
          if (md_done) begin
            state   <= DONE;
            out_q   <= iter_res;
            flags_q <= iter_flags;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            if (bus.in_valid) state <= is_iter_op(bus.opcode) ? ITER : EXEC;
            else              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: unsigned-compare instance plus a signed-compare instance.
module tb_ula_seq;
  import ula_seq_pkg::*;

  typedef struct {
    logic [10:0] res;
    logic [4:0]  flg;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  ula_seq_if #(.DATA_SIZE(11)) bus0 ();
  ula_seq_if #(.DATA_SIZE(11)) bus1 ();

  ula_seq #(.DATA_SIZE(11), .SIGNED_CMP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ula_seq #(.DATA_SIZE(11), .SIGNED_CMP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_output got %0d expected none", bus0.out);
      end else begin
        e = q0.pop_front();
        chk({e.name, "_out"}, 32'(bus0.out), 32'(e.res));
        chk({e.name, "_flags"}, 32'(bus0.flags), 32'(e.flg));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_output got %0d expected none", bus1.out);
      end else begin
        e = q1.pop_front();
        chk({e.name, "_out"}, 32'(bus1.out), 32'(e.res));
        chk({e.name, "_flags"}, 32'(bus1.flags), 32'(e.flg));
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input logic [3:0] op,
                       input logic [10:0] a, input logic [10:0] b);
    if (sel) begin
      bus1.in_valid = v; bus1.opcode = op; bus1.operand_a = a; bus1.operand_b = b;
    end else begin
      bus0.in_valid = v; bus0.opcode = op; bus0.operand_a = a; bus0.operand_b = b;
    end
  endtask

  task automatic push(input bit sel, input logic [10:0] er, input logic [4:0] ef, input string name);
    exp_t e;
    e.res = er; e.flg = ef; e.name = name;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  task automatic send(input bit sel, input logic [3:0] op, input logic [10:0] a, input logic [10:0] b,
                      input bit do_push, input logic [10:0] er, input logic [4:0] ef, input string name);
    int n;
    if (do_push) push(sel, er, ef, name);
    drive(sel, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!(sel ? bus1.in_ready : bus0.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_accept got timeout expected in_ready", name);
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, op, a, b);
  endtask

  // Called right after send returns; counts edges from the accept edge to out_valid.
  task automatic wait_valid(input bit sel, input int exp_lat, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!(sel ? bus1.out_valid : bus0.out_valid) && n < 60);
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 11'd0, 11'd0);
    drive(1'b1, 1'b0, 4'd0, 11'd0, 11'd0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_out", 32'(bus0.out), 32'd0);
    chk("rst_flags", 32'(bus0.flags), 32'd0);
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("rst_in_ready1", 32'(bus1.in_ready), 32'd1);

    send(0, OP_ADD, 11'd2000, 11'd100, 1, 11'd52, 5'b00010, "add_carry");
    wait_valid(0, 1, "add");
    send(0, OP_MUL, 11'd45, 11'd45, 1, 11'd2025, 5'b00000, "mul_45");
    wait_valid(0, 12, "mul");
    send(0, OP_MUL, 11'd64, 11'd64, 1, 11'd0, 5'b00101, "mul_ovf");
    send(0, OP_DIV, 11'd100, 11'd7, 1, 11'd14, 5'b00000, "div_100_7");
    send(0, OP_MOD, 11'd100, 11'd7, 1, 11'd2, 5'b00000, "mod_100_7");
    send(0, OP_DIV, 11'd100, 11'd0, 1, 11'd2047, 5'b01000, "div_zero");
    wait_valid(0, 12, "div_zero");
    send(0, OP_MOD, 11'd100, 11'd0, 1, 11'd100, 5'b01000, "mod_zero");
    send(0, OP_SUB, 11'd5, 11'd9, 1, 11'd2044, 5'b00010, "sub_borrow");
    send(0, OP_SUB, 11'd9, 11'd5, 1, 11'd4, 5'b00000, "sub_plain");
    send(0, OP_AND,  11'd1445, 11'd240, 1, 11'd160,  5'b00000, "and");
    send(0, OP_NAND, 11'd1445, 11'd240, 1, 11'd1887, 5'b00000, "nand");
    send(0, OP_OR,   11'd1445, 11'd240, 1, 11'd1525, 5'b00000, "or");
    send(0, OP_XOR,  11'd1445, 11'd240, 1, 11'd1365, 5'b00000, "xor");
    send(0, OP_NOT,  11'd1445, 11'd1234, 1, 11'd602, 5'b00000, "not");
    send(0, OP_CMP, 11'd5, 11'd9, 1, 11'd2047, 5'b00000, "cmp_lt");
    send(0, OP_CMP, 11'd9, 11'd5, 1, 11'd1, 5'b00000, "cmp_gt");
    send(0, OP_CMP, 11'd7, 11'd7, 1, 11'd0, 5'b00001, "cmp_eq");
    send(0, OP_CMP, 11'd2047, 11'd1, 1, 11'd1, 5'b00000, "cmp_unsigned");
    send(0, OP_SHL, 11'd3, 11'd4, 1, 11'd48, 5'b00000, "shl");
    send(0, OP_SHL, 11'd1, 11'd11, 1, 11'd0, 5'b00001, "shl_wide");
    send(0, OP_SHR, 11'd1024, 11'd3, 1, 11'd128, 5'b00000, "shr");
    send(0, OP_SHR, 11'd2047, 11'd20, 1, 11'd0, 5'b00001, "shr_wide");
    send(0, 4'd14, 11'd5, 11'd6, 1, 11'd0, 5'b10001, "illegal14");
    send(0, 4'd13, 11'd5, 11'd6, 1, 11'd0, 5'b10001, "illegal13");
    send(0, 4'd15, 11'd5, 11'd6, 1, 11'd0, 5'b10001, "illegal15");

    send(1, OP_CMP, 11'd2047, 11'd1, 1, 11'd2047, 5'b00000, "scmp_neg1");
    wait_valid(1, 1, "scmp");
    send(1, OP_CMP, 11'd1, 11'd2047, 1, 11'd1, 5'b00000, "scmp_gt");
    send(1, OP_CMP, 11'd1024, 11'd1023, 1, 11'd2047, 5'b00000, "scmp_min");
    drain();

    // Backpressure: result must hold while the consumer stalls
    bus0.out_ready = 1'b0;
    send(0, OP_ADD, 11'd1, 11'd2, 1, 11'd3, 5'b00000, "bp_add");
    wait_valid(0, 1, "bp_add");
    drive(0, 1'b1, OP_SUB, 11'd10, 11'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out", 32'(bus0.out), 32'd3);
      chk("bp_flags", 32'(bus0.flags), 32'd0);
      chk("bp_out_valid", 32'(bus0.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus0.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b1;
    push(0, 11'd7, 5'b00000, "b2b_sub");
    #1;
    chk("b2b_in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, OP_SUB, 11'd0, 11'd0);
    wait_valid(0, 1, "b2b_sub");
    drain();

    // Reset four cycles into a divide: no result may appear
    send(0, OP_DIV, 11'd100, 11'd7, 0, 11'd0, 5'b00000, "div_abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("abort_out", 32'(bus0.out), 32'd0);
    chk("abort_flags", 32'(bus0.flags), 32'd0);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);

    // Reset and accept on the same edge: request dropped
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b1, OP_ADD, 11'd1, 11'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, OP_ADD, 11'd0, 11'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("rst_accept_dropped", 32'(seen), 32'd0);

    send(0, 4'd14, 11'd9, 11'd9, 1, 11'd0, 5'b10001, "post_rst_illegal");
    send(0, OP_ADD, 11'd7, 11'd8, 1, 11'd15, 5'b00000, "post_rst_add");
    drain();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
